// File: rtl/bram_pkg.sv
// ----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the BRAM access controller: access-size encodings,
// controller FSM states, the default BRAM word-address width and the
// alignment helper used at request accept.
// ----------------------------------------------------------------------------
package bram_pkg;

    // Default BRAM word-address width (16384 x 32-bit words).
    localparam int WADDR_W_DEF = 14;

    // Request access size, as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_WAIT  = 2'b01,
        RMW_WAIT = 2'b10
    } state_e;

    // A request is rejected when its size is illegal or its byte address is
    // not a multiple of the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_unit.sv
// ----------------------------------------------------------------------------
// lane_unit
// Combinational little-endian lane logic for sub-word accesses.
//   rdata   in  32  word read from the BRAM
//   lane    in  2   byte offset within the word (addr[1:0])
//   size    in  2   access size (byte / half / word)
//   sgn     in  1   sign-extend loaded byte/half
//   wdata   in  32  store data; only the low 8/16 bits are merged
//   ld_data out 32  addressed lane(s) zero- or sign-extended to 32 bits
//   st_data out 32  rdata with the addressed lane(s) replaced by wdata
// ----------------------------------------------------------------------------
module lane_unit
    import bram_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane k occupies bits 8k+7:8k; a halfword uses lane pair lane[1].
    assign byte_sel = rdata[{lane, 3'b000} +: 8];
    assign half_sel = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = rdata;
        st_data = rdata;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
                st_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{sgn & half_sel[15]}}, half_sel};
                st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ld_data = rdata;
                st_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/bram_access_ctrl.sv
// ----------------------------------------------------------------------------
// bram_access_ctrl
// Byte/half/word load-store front end for a single-port, read-first BRAM with
// one-cycle read latency. Sub-word stores are done as read-modify-write.
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we, req_size, req_signed   store flag, access size, sign-extend loads
//   req_addr, req_wdata            byte address, store data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response pulse
//   ram_en, ram_we, ram_addr       BRAM control, word address
//   ram_di, ram_dout               BRAM write / read data
//   fsm_state                      current controller state (debug)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE outside reset, and
// req_* inputs are ignored otherwise. Every transferred request yields exactly
// one rsp_valid pulse, in request order.
// ----------------------------------------------------------------------------
module bram_access_ctrl
    import bram_pkg::*;
#(
    parameter int WADDR_W = WADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout,
    output state_e      fsm_state
);

    state_e      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    size_e       size_q;
    logic        sgn_q;

    logic        accept;
    logic        req_mis;
    logic [31:0] addr_sel;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic        unused_addr_bits;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_mis   = misaligned(req_size, req_addr[1:0]);
    assign fsm_state = state;

    // In IDLE the RAM is addressed straight from the request so the access
    // starts in the accept cycle; in the wait states the latched address is used.
    assign addr_sel = (state == IDLE) ? req_addr : addr_q;
    assign ram_addr = {{(32 - WADDR_W){1'b0}}, addr_sel[WADDR_W+1:2]};
    assign unused_addr_bits = ^{addr_sel[31:WADDR_W+2], addr_sel[1:0]};

    lane_unit u_lane (
        .rdata   (ram_dout),
        .lane    (addr_q[1:0]),
        .size    (size_q),
        .sgn     (sgn_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    // RAM strobes are combinational; gating with rst abandons an in-flight
    // RMW write when reset lands in RMW_WAIT.
    always_comb begin
        ram_en = 1'b0;
        ram_we = 1'b0;
        ram_di = wdata_q;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (accept && !req_mis) begin
                        ram_en = 1'b1;
                        if (req_we && (req_size == SZ_WORD)) begin
                            ram_we = 1'b1;
                            ram_di = req_wdata;
                        end
                    end
                end
                RMW_WAIT: begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    ram_di = st_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        size_q  <= size_e'(req_size);
                        sgn_q   <= req_signed;
                        wdata_q <= req_wdata;
                        if (req_mis) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state <= LD_WAIT;
                        end else if (req_size == SZ_WORD) begin
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= RMW_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                    state     <= IDLE;
                end
                RMW_WAIT: begin
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_access_ctrl.sv
module tb_bram_access_ctrl;
  import bram_pkg::*;

  localparam int WW = 14;
  localparam int NW = 1 << WW;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;
  state_e      fsm_state;

  always #5 clk = ~clk;

  bram_access_ctrl #(.WADDR_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_dout   (ram_dout),
    .fsm_state  (fsm_state)
  );

  // Single-port read-first BRAM, one-cycle read latency.
  logic [31:0] mem [NW];
  logic        fill;

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_val(i);
    end else if (ram_en) begin
      ram_dout <= mem[ram_addr[WW-1:0]];
      if (ram_we) mem[ram_addr[WW-1:0]] <= ram_di;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [NW];
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-array view of memory, alignment as "offset is a
  // multiple of the access size", load/store latency from the access kind.
  task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat);
    int          w, nb, off;
    logic [7:0]  bytes [4];
    longint      val;
    w   = int'(addr[WW+1:2]);
    off = int'(addr[1:0]);
    nb  = 1 << sz;
    rd  = '0;
    err = (sz == 2'b11) || ((off % nb) != 0);
    if (err) begin
      lat = 1;
      return;
    end
    for (int i = 0; i < 4; i++) bytes[i] = ref_mem[w][8*i +: 8];
    if (!we) begin
      val = 0;
      for (int i = 0; i < nb; i++) val = val | (longint'(bytes[off+i]) << (8*i));
      if (sgn && val[8*nb-1]) val = val - (longint'(1) << (8*nb));
      rd  = val[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < nb; i++) bytes[off+i] = wd[8*i +: 8];
      ref_mem[w] = {bytes[3], bytes[2], bytes[1], bytes[0]};
      lat = (nb == 4) ? 1 : 2;
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation, in the
  // exact cycle; an expectation whose cycle passes without a pulse is a miss.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_rsp observed=rsp_valid expected=none cyc=%0d", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("missing_rsp", {31'b0, rsp_valid}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, output int acc);
    int   budget;
    logic err;
    logic [31:0] rd;
    int   lat;
    exp_t e;
    budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    acc = cyc;
    model(we, sz, sgn, addr, wd, err, rd, lat);
    e.cyc  = acc + lat;
    e.err  = err;
    e.data = rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic ready_at_negedge(input string tag, input logic exp);
    @(negedge clk);
    check(tag, {31'b0, req_ready}, {31'b0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc, acc0, acc_last, mism;
    logic [31:0] wd, mem8_before;

    rst = 1'b1; fill = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
    @(negedge clk);
    fill = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_ram_en", {31'b0, ram_en}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    rst = 1'b0;
    #1 check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Word store then load
    issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, acc);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, acc);
    drain();
    check("sw_mem4", mem[4], 32'hDEADBEEF);

    // Signed / unsigned sub-word loads
    issue(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, acc);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, acc);
    issue(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, acc);
    issue(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, acc);
    drain();

    // RMW byte store: one busy cycle, ack at accept+2
    issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h55, acc);
    ready_at_negedge("sb_busy", 1'b0);
    ready_at_negedge("sb_ready_again", 1'b1);
    drain();
    check("sb_mem4", mem[4], 32'hDEAD55EF);

    // Misaligned and illegal-size requests
    issue(1'b1, SZ_WORD, 1'b0, 32'h12, 32'h12345678, acc);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, acc);
    issue(1'b1, SZ_HALF, 1'b0, 32'h11, 32'hAAAA, acc);
    drain();
    check("mis_mem4", mem[4], 32'hDEAD55EF);

    // Reset during RMW_WAIT of sh 0x20
    mem8_before = ref_mem[8];
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_HALF; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFE; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_state", 32'(fsm_state), 32'(RMW_WAIT));
    rst = 1'b1;
    #1;
    check("rmw_rst_ram_en", {31'b0, ram_en}, 32'd0);
    check("rmw_rst_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rmw_ready_after_rst", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("rmw_mem8_unchanged", mem[8], mem8_before);

    // Throughput: 8 back-to-back word stores, acks on consecutive cycles
    acc0 = 0; acc_last = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, SZ_WORD, 1'b0, 32'h100 + 32'(4*i), $urandom, acc);
      if (i == 0) acc0 = acc;
      acc_last = acc;
    end
    drain();
    check("b2b_span", acc_last - acc0, 7);

    // Address wrap
    wd = $urandom;
    issue(1'b1, SZ_WORD, 1'b0, 32'h00010010, wd, acc);
    drain();
    check("wrap_mem4", mem[4], wd);

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {14'b0, 2'(($urandom_range(0, 3))), 10'b0, 6'($urandom_range(0, 63))};
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    mism = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_final", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
